// File: rtl/large_ram_arbiter.sv
// Two-port arbiter that sequences one synchronous RAM with a shared tri-state data bus.
// Define RAM_ARB_FIXED_PRIORITY_EN for fixed port-0 priority; default is round-robin.
module large_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_chip_select,
    output logic                  ram_write_enable,
    output logic                  ram_output_enable,
    output logic                  busy
);

    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic                  owner, owner_nxt;
    logic [CNT_W-1:0]      lat_cnt, lat_cnt_nxt;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
    logic [DATA_WIDTH-1:0] rdata0_nxt, rdata1_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  gnt0_nxt, gnt1_nxt, rvalid0_nxt, rvalid1_nxt;
    logic                  cs_nxt, we_nxt, oe_nxt, busy_nxt;
    logic                  accept;
    logic                  pick1;

    // Bus is released in the same registered update that raises output_enable.
    assign ram_data = ram_output_enable ? {DATA_WIDTH{1'bz}} : wdata_q;

    assign accept = (state == IDLE) && (req0 || req1);

`ifdef RAM_ARB_FIXED_PRIORITY_EN
    assign pick1 = req1 && !req0;
`else
    logic last_grant;

    // Port that did not win last time takes a tie; reset favours port 0.
    assign pick1 = req1 && (!req0 || !last_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= pick1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            owner             <= 1'b0;
            lat_cnt           <= '0;
            wdata_q           <= '0;
            gnt0              <= 1'b0;
            gnt1              <= 1'b0;
            rvalid0           <= 1'b0;
            rvalid1           <= 1'b0;
            rdata0            <= '0;
            rdata1            <= '0;
            ram_addr          <= '0;
            ram_chip_select   <= 1'b0;
            ram_write_enable  <= 1'b0;
            ram_output_enable <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state             <= state_nxt;
            owner             <= owner_nxt;
            lat_cnt           <= lat_cnt_nxt;
            wdata_q           <= wdata_nxt;
            gnt0              <= gnt0_nxt;
            gnt1              <= gnt1_nxt;
            rvalid0           <= rvalid0_nxt;
            rvalid1           <= rvalid1_nxt;
            rdata0            <= rdata0_nxt;
            rdata1            <= rdata1_nxt;
            ram_addr          <= addr_nxt;
            ram_chip_select   <= cs_nxt;
            ram_write_enable  <= we_nxt;
            ram_output_enable <= oe_nxt;
            busy              <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        lat_cnt_nxt = lat_cnt;
        wdata_nxt   = wdata_q;
        gnt0_nxt    = 1'b0;
        gnt1_nxt    = 1'b0;
        rvalid0_nxt = 1'b0;
        rvalid1_nxt = 1'b0;
        rdata0_nxt  = rdata0;
        rdata1_nxt  = rdata1;
        addr_nxt    = ram_addr;
        cs_nxt      = ram_chip_select;
        we_nxt      = ram_write_enable;
        oe_nxt      = ram_output_enable;

        case (state)
            IDLE: begin
                cs_nxt = 1'b0;
                we_nxt = 1'b0;
                oe_nxt = 1'b0;
                if (accept) begin
                    owner_nxt   = pick1;
                    addr_nxt    = pick1 ? addr1 : addr0;
                    wdata_nxt   = pick1 ? wdata1 : wdata0;
                    we_nxt      = pick1 ? we1 : we0;
                    oe_nxt      = !(pick1 ? we1 : we0);
                    cs_nxt      = 1'b1;
                    gnt0_nxt    = !pick1;
                    gnt1_nxt    = pick1;
                    lat_cnt_nxt = CNT_W'(READ_LATENCY - 1);
                    state_nxt   = (pick1 ? we1 : we0) ? WRITE : READ;
                end
            end
            WRITE: begin
                cs_nxt    = 1'b0;
                we_nxt    = 1'b0;
                state_nxt = IDLE;
            end
            READ: begin
                if (lat_cnt == '0) begin
                    if (owner) begin
                        rdata1_nxt = ram_data;
                    end else begin
                        rdata0_nxt = ram_data;
                    end
                    state_nxt = DONE;
                end else begin
                    lat_cnt_nxt = lat_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                rvalid0_nxt = !owner;
                rvalid1_nxt = owner;
                cs_nxt      = 1'b0;
                oe_nxt      = 1'b0;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Busy stays up through the cycle in which the access's controls drop.
        busy_nxt = (state != IDLE) || accept;
    end

endmodule

// File: tb/tb_large_ram_arbiter.sv
// Directed bench for large_ram_arbiter with a behavioural tri-state RAM and a bus/grant monitor.
// Build with RAM_ARB_FIXED_PRIORITY_EN to expect fixed-priority grant ordering.
module tb_large_ram_arbiter;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;
    localparam int unsigned RL = 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_chip_select, ram_write_enable, ram_output_enable, busy;

    int total = 0;
    int bad   = 0;

    large_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_chip_select(ram_chip_select), .ram_write_enable(ram_write_enable),
        .ram_output_enable(ram_output_enable), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: writes on posedge, drives the bus while selected for read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign ram_data = (ram_chip_select && ram_output_enable && !ram_write_enable) ? mem[ram_addr] : {DW{1'bz}};
    always @(posedge clk) if (ram_chip_select && ram_write_enable) mem[ram_addr] <= ram_data;

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ((gnt0 && gnt1) !== 1'b0) begin
                bad++; $display("FAIL dual_gnt t=%0t gnt0=%b gnt1=%b exp not both", $time, gnt0, gnt1);
            end
            total++;
            if (ram_output_enable ? (ram_chip_select && (ram_data !== mem[ram_addr])) : ((^ram_data) === 1'bx)) begin
                bad++; $display("FAIL bus_contention t=%0t oe=%b ram_data=%h exp clean bus", $time, ram_output_enable, ram_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, ram_chip_select, ram_write_enable, ram_output_enable, busy} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000000", {gnt0, gnt1, rvalid0, rvalid1, ram_chip_select, ram_write_enable, ram_output_enable, busy});
        end
        total++;
        if ({rdata0, rdata1, ram_addr, ram_data} !== 60'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {rdata0, rdata1, ram_addr, ram_data});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h3FC; wdata0 = 16'h1234;
        tick();
        total++;
        if ({gnt0, gnt1, ram_chip_select, ram_write_enable, ram_output_enable, busy} !== 6'b101101) begin
            bad++; $display("FAIL write_gnt got=%b exp=101101", {gnt0, gnt1, ram_chip_select, ram_write_enable, ram_output_enable, busy});
        end
        total++;
        if ({ram_addr, ram_data} !== {12'h3FC, 16'h1234}) begin
            bad++; $display("FAIL write_bus got=%h/%h exp=3fc/1234", ram_addr, ram_data);
        end
        req0 = 1'b0;
        tick();
        total++;
        if ({gnt0, ram_chip_select, ram_write_enable, busy} !== 4'b0001) begin
            bad++; $display("FAIL write_end got=%b exp=0001", {gnt0, ram_chip_select, ram_write_enable, busy});
        end
        tick();
        total++;
        if ({busy, mem[12'h3FC]} !== {1'b0, 16'h1234}) begin
            bad++; $display("FAIL write_done busy=%b mem=%h exp=0/1234", busy, mem[12'h3FC]);
        end
    endtask

    task automatic test_read_back();
        int n;
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h3FC;
        tick();
        total++;
        if ({gnt0, gnt1, ram_chip_select, ram_write_enable, ram_output_enable} !== 5'b01101) begin
            bad++; $display("FAIL read_gnt got=%b exp=01101", {gnt0, gnt1, ram_chip_select, ram_write_enable, ram_output_enable});
        end
        req1 = 1'b0;
        n = 0;
        while (rvalid1 !== 1'b1 && n < 10) begin tick(); n++; end
        total++;
        if ({rvalid0, rvalid1, rdata1, n} !== {1'b0, 1'b1, 16'h1234, RL + 1}) begin
            bad++; $display("FAIL read_data rvalid1=%b rdata1=%h lat=%0d exp=1/1234/%0d", rvalid1, rdata1, n, RL + 1);
        end
        tick();
        total++;
        if ({rvalid1, rdata1, busy, ram_chip_select, ram_output_enable} !== {1'b0, 16'h1234, 3'b000}) begin
            bad++; $display("FAIL read_after rvalid1=%b rdata1=%h busy/cs/oe=%b exp=0/1234/000", rvalid1, rdata1, {busy, ram_chip_select, ram_output_enable});
        end
    endtask

    task automatic test_tie_after_reset();
        int n;
        logic [DW-1:0] exp;
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h7FC; wdata0 = 16'h5A5A;
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'hBFC; wdata1 = 16'hA5A5;
        tick();
        total++;
        if ({gnt0, gnt1, ram_addr, ram_data} !== {2'b10, 12'h7FC, 16'h5A5A}) begin
            bad++; $display("FAIL tie_first got=%b %h %h exp=10 7fc 5a5a", {gnt0, gnt1}, ram_addr, ram_data);
        end
        req0 = 1'b0;
        tick();
        total++;
        if ({gnt0, gnt1} !== 2'b00) begin
            bad++; $display("FAIL tie_gap got=%b exp=00", {gnt0, gnt1});
        end
        tick();
        total++;
        if ({gnt0, gnt1, ram_addr, ram_data} !== {2'b01, 12'hBFC, 16'hA5A5}) begin
            bad++; $display("FAIL tie_second got=%b %h %h exp=01 bfc a5a5", {gnt0, gnt1}, ram_addr, ram_data);
        end
        req1 = 1'b0;
        tick(); tick();
        for (int p = 0; p < 2; p++) begin
            exp = (p == 1) ? 16'hA5A5 : 16'h5A5A;
            if (p == 0) begin req0 = 1'b1; we0 = 1'b0; addr0 = 12'h7FC; end
            else begin req1 = 1'b1; we1 = 1'b0; addr1 = 12'hBFC; end
            tick();
            req0 = 1'b0; req1 = 1'b0;
            n = 0;
            while (!(rvalid0 || rvalid1) && n < 10) begin tick(); n++; end
            total++;
            if ({rvalid0, rvalid1, (p == 1) ? rdata1 : rdata0} !== {p == 0, p == 1, exp}) begin
                bad++; $display("FAIL tie_readback port=%0d rvalid=%b rdata=%h exp=%h", p, {rvalid0, rvalid1}, (p == 1) ? rdata1 : rdata0, exp);
            end
            tick();
        end
    endtask

    task automatic test_sustained_tie();
        int n0, n1, k, cyc;
        logic seq [16];
        int   at  [16];
        logic exp_port;
        n0 = 0; n1 = 0; k = 0; cyc = 0;
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h100; wdata0 = 16'h0100;
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h200; wdata1 = 16'h0200;
        while (k < 16 && cyc < 100) begin
            tick(); cyc++;
            if (gnt0 === 1'b1 && k < 16) begin
                seq[k] = 1'b0; at[k] = cyc; k++; n0++;
                addr0 = AW'(32'h100 + n0); wdata0 = DW'(32'h0100 + n0);
                if (n0 == 8) req0 = 1'b0;
            end
            if (gnt1 === 1'b1 && k < 16) begin
                seq[k] = 1'b1; at[k] = cyc; k++; n1++;
                addr1 = AW'(32'h200 + n1); wdata1 = DW'(32'h0200 + n1);
                if (n1 == 8) req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (k !== 16) begin
            bad++; $display("FAIL sustained_count got=%0d exp=16", k);
        end
        for (int i = 0; i < k; i++) begin
`ifdef RAM_ARB_FIXED_PRIORITY_EN
            exp_port = (i >= 8);
`else
            exp_port = (i % 2) == 1;
`endif
            total++;
            if ({seq[i], at[i]} !== {exp_port, at[0] + 2 * i}) begin
                bad++; $display("FAIL sustained_order op=%0d port=%b cyc=%0d exp=%b/%0d", i, seq[i], at[i], exp_port, at[0] + 2 * i);
            end
        end
        tick(); tick();
    endtask

    task automatic test_corners();
        int n;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            a = (c == 1) ? 12'hFFF : 12'h000;
            d = (c == 1) ? 16'hC0DE : 16'hBEEF;
            req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d;
            tick();
            req1 = 1'b0;
            total++;
            if ({gnt1, ram_addr, ram_data} !== {1'b1, a, d}) begin
                bad++; $display("FAIL corner_write got=%b %h %h exp=1 %h %h", gnt1, ram_addr, ram_data, a, d);
            end
            tick(); tick();
            req0 = 1'b1; we0 = 1'b0; addr0 = a;
            tick();
            req0 = 1'b0;
            n = 0;
            while (rvalid0 !== 1'b1 && n < 10) begin tick(); n++; end
            total++;
            if ({rvalid0, rdata0, n} !== {1'b1, d, RL + 1}) begin
                bad++; $display("FAIL corner_read addr=%h rvalid0=%b rdata0=%h lat=%0d exp=1/%h/%0d", a, rvalid0, rdata0, n, d, RL + 1);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        logic seen;
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'hFFF;
        tick();
        req0 = 1'b0;
        total++;
        if ({gnt0, ram_output_enable, busy} !== 3'b111) begin
            bad++; $display("FAIL midrd_start got=%b exp=111", {gnt0, ram_output_enable, busy});
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, ram_chip_select, ram_write_enable, ram_output_enable, busy, rdata0, ram_addr, ram_data} !== 52'h0) begin
            bad++; $display("FAIL midrd_reset ctrl=%b rdata0=%h addr=%h data=%h exp=0", {gnt0, gnt1, rvalid0, rvalid1, ram_chip_select, ram_write_enable, ram_output_enable, busy}, rdata0, ram_addr, ram_data);
        end
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rvalid0 !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL midrd_no_rvalid got=stray strobe exp=none");
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_back();
        test_tie_after_reset();
        test_sustained_tie();
        test_corners();
        test_reset_mid_read();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
